// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout, parity encodings and FSM states.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    // Parity type encodings (PAR_TYP input)
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Line levels for frame delimiters
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Parity bit for a data byte: even -> XOR of bits, odd -> inverted XOR.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                         input logic                 par_typ);
        return (par_typ == PAR_EVEN) ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Prescale cycle counter: strobes o_bit_done on the last cycle of each bit time.
module uart_tx_bit_timer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_en,
    input  logic       i_clear,
    input  logic [5:0] i_prescale,
    output logic       o_bit_done
);

    logic [5:0] r_cnt;
    logic [5:0] w_last;

    // Prescale 0 behaves as 1, so its terminal count is also 0.
    assign w_last     = (i_prescale == 6'd0) ? 6'd0 : i_prescale - 6'd1;
    assign o_bit_done = i_en && (r_cnt == w_last);

    // Count while enabled; restart on every bit boundary, on clear, or when idle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= 6'd0;
        end else if (i_clear || o_bit_done || !i_en) begin
            r_cnt <= 6'd0;
        end else begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
module uart_tx_top
    import uart_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] Prescale,
    output logic       TX_OUT,
    output logic       busy
);

    uart_state_e          r_state;
    uart_state_e          w_state_d;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_en;
    logic                 r_parity;
    logic [5:0]           r_prescale;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_d;
    logic                 r_tx;
    logic                 w_tx_d;
    logic                 r_busy;
    logic                 w_busy_d;
    logic                 w_accept;
    logic                 w_bit_done;

    assign w_accept = (r_state == StIdle) && Data_Valid;

    uart_tx_bit_timer u_bit_timer (
        .CLK        (CLK),
        .RST        (RST),
        .i_en       (r_state != StIdle),
        .i_clear    (w_accept),
        .i_prescale (r_prescale),
        .o_bit_done (w_bit_done)
    );

    // Shadow copies of the request; the parity bit is resolved once here.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_parity   <= 1'b0;
            r_prescale <= 6'd0;
        end else if (w_accept) begin
            r_data     <= P_DATA;
            r_par_en   <= PAR_EN;
            r_parity   <= calc_parity(P_DATA, PAR_TYP);
            r_prescale <= Prescale;
        end
    end

    // Next-state and bit index sequencing.
    always_comb begin
        w_state_d   = r_state;
        w_bit_idx_d = r_bit_idx;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_bit_done) begin
                    w_state_d   = StData;
                    w_bit_idx_d = 3'd0;
                end
            end
            StData: begin
                if (w_bit_done) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_bit_idx_d = 3'd0;
                        w_state_d   = r_par_en ? StParity : StStop;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 3'd1;
                    end
                end
            end
            StParity: begin
                if (w_bit_done) begin
                    w_state_d = StStop;
                end
            end
            StStop: begin
                if (w_bit_done) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Line level and busy are decoded from the next state so both come straight from flops.
    always_comb begin
        w_tx_d   = STOP_BIT;
        w_busy_d = 1'b1;
        unique case (w_state_d)
            StIdle: begin
                w_tx_d   = STOP_BIT;
                w_busy_d = 1'b0;
            end
            StStart:  w_tx_d = START_BIT;
            StData:   w_tx_d = r_data[w_bit_idx_d];
            StParity: w_tx_d = r_parity;
            StStop:   w_tx_d = STOP_BIT;
            default: begin
                w_tx_d   = STOP_BIT;
                w_busy_d = 1'b0;
            end
        endcase
    end

    // State, index and registered outputs; reset forces an idle line immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= StIdle;
            r_bit_idx <= 3'd0;
            r_tx      <= STOP_BIT;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_bit_idx <= w_bit_idx_d;
            r_tx      <= w_tx_d;
            r_busy    <= w_busy_d;
        end
    end

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_top.sv
// Self-checking bench for uart_tx_top: frame-level model plus directed literal checks.
module tb_uart_tx_top;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd0;
    logic       TX_OUT;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    always #5 CLK = ~CLK;

    uart_tx_top dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is an array of line levels, each held m_p cycles.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    int          m_len = 10;
    int          m_p = 1;
    logic [10:0] m_frame = '1;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            if (m_cnt + 1 == m_len * m_p) m_busy <= 1'b0;
            m_cnt <= m_cnt + 1;
        end else if (Data_Valid) begin
            m_p     <= (Prescale == 6'd0) ? 1 : int'(Prescale);
            m_len   <= PAR_EN ? 11 : 10;
            m_frame <= {1'b1, PAR_EN ? ((^P_DATA) ^ PAR_TYP) : 1'b1, P_DATA, 1'b0};
            m_cnt   <= 0;
            m_busy  <= 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("tx_vs_model", {31'd0, TX_OUT}, {31'd0, m_busy ? m_frame[m_cnt / m_p] : 1'b1});
            check("busy_vs_model", {31'd0, busy}, {31'd0, m_busy});
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Sends one request and records the first sample of each bit and the busy length.
    task automatic capture(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [5:0] ps, input bit inject,
                           output logic [10:0] bits, output int bcyc);
        int pe_n;
        int k;
        pe_n = (ps == 6'd0) ? 1 : int'(ps);
        wait_idle();
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        bits = '1;
        bcyc = 0;
        k = 0;
        while (busy && k < 3000) begin
            if ((k % pe_n) == 0 && (k / pe_n) < 11) bits[k / pe_n] = TX_OUT;
            if (inject && k == 20) begin
                Data_Valid = 1'b1; P_DATA = 8'h00; Prescale = 6'd4;
            end else if (inject && k == 21) begin
                Data_Valid = 1'b0;
            end
            bcyc++;
            k++;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [10:0] bits;
        int          bc;
        int          lows;
        int          gaps;
        int          n;
        bit          seen_high;

        repeat (3) @(negedge CLK);
        check("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        RST = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge CLK);

        capture(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, bits, bc);
        check("a5_even_bits", {21'd0, bits}, {21'd0, 11'b1_0_10100101_0});
        check("a5_even_busy", bc, 88);

        capture(8'h01, 1'b1, 1'b1, 6'd16, 1'b0, bits, bc);
        check("01_odd_bits", {21'd0, bits}, {21'd0, 11'b1_0_00000001_0});
        check("01_odd_busy", bc, 176);

        capture(8'h01, 1'b1, 1'b0, 6'd16, 1'b0, bits, bc);
        check("01_even_bits", {21'd0, bits}, {21'd0, 11'b1_1_00000001_0});
        check("01_even_busy", bc, 176);

        capture(8'hFF, 1'b0, 1'b0, 6'd1, 1'b0, bits, bc);
        check("ff_p1_bits", {21'd0, bits}, {21'd0, 11'b11_11111111_0});
        check("ff_p1_busy", bc, 10);

        capture(8'hFF, 1'b0, 1'b0, 6'd0, 1'b0, bits, bc);
        check("ff_p0_bits", {21'd0, bits}, {21'd0, 11'b11_11111111_0});
        check("ff_p0_busy", bc, 10);

        // Request while busy must be dropped, and the frame unaffected.
        capture(8'hC3, 1'b0, 1'b0, 6'd8, 1'b1, bits, bc);
        check("inject_bits", {21'd0, bits}, {21'd0, 11'b11_11000011_0});
        check("inject_busy", bc, 80);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (TX_OUT === 1'b0 || busy === 1'b1) lows++;
        end
        check("inject_never_sent", lows, 0);

        // Level-held request: frames back to back with one idle cycle between.
        wait_idle();
        @(negedge CLK);
        P_DATA = 8'h3C; PAR_EN = 1'b0; Prescale = 6'd2; Data_Valid = 1'b1;
        gaps = 0; lows = 0; n = 0; seen_high = 1'b0;
        while (gaps < 2 && n < 500) begin
            @(negedge CLK);
            n++;
            if (busy) begin
                if (seen_high && lows > 0) begin
                    check("b2b_gap", lows, 1);
                    gaps++;
                end
                seen_high = 1'b1;
                lows = 0;
            end else if (seen_high) begin
                lows++;
            end
        end
        check("b2b_gaps_seen", gaps, 2);
        Data_Valid = 1'b0;
        wait_idle();

        // Asynchronous reset during data bit 3.
        @(negedge CLK);
        P_DATA = 8'h52; PAR_EN = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (17) @(negedge CLK);
        check("pre_rst_tx", {31'd0, TX_OUT}, 32'd0);
        #2 RST = 1'b0;
        #1;
        check("rst_async_tx", {31'd0, TX_OUT}, 32'd1);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (TX_OUT === 1'b0 || busy === 1'b1) lows++;
        end
        check("post_rst_idle", lows, 0);

        // Random traffic, including requests and input churn while busy.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            Prescale   = 6'($urandom_range(0, 7));
            Data_Valid = ($urandom_range(0, 3) == 0);
        end
        Data_Valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
